// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the stall/flush controller.
// The master is the datapath side. The slave is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_use;
    logic             id_rt_use;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             id_halt;
    logic             go;
    logic             id_md_start;
    logic             md_done;

    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_clr;
    logic             id_ex_clr;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output id_rs, id_rt, id_rs_use, id_rt_use, ex_memread, ex_rd,
               ex_branch_taken, id_halt, go, id_md_start, md_done,
        input  pc_hold, if_id_hold, if_id_clr, id_ex_clr, halted,
               stall_cnt, flush_cnt, dbg_state
    );

    modport slave (
        input  id_rs, id_rt, id_rs_use, id_rt_use, ex_memread, ex_rd,
               ex_branch_taken, id_halt, go, id_md_start, md_done,
        output pc_hold, if_id_hold, if_id_clr, id_ex_clr, halted,
               stall_cnt, flush_cnt, dbg_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. It handles load-use, branch, mult/div and halt.
// Define PIPE_HAZARD_CTRL_CNT_EN to build the saturating stall/flush counters. Without it they read 0.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_hz;
    logic   w_pc_hold;
    logic   w_if_id_hold;
    logic   w_if_id_clr;
    logic   w_id_ex_clr;
    logic   w_halted;

    assign w_hz = bus.ex_memread && (bus.ex_rd != {REG_W{1'b0}}) &&
                  ((bus.id_rs_use && (bus.id_rs == bus.ex_rd)) ||
                   (bus.id_rt_use && (bus.id_rt == bus.ex_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_next;
    end

    // A stall holds PC and IF/ID and pushes a bubble into ID/EX. A flush clears both registers.
    always_comb begin
        w_next       = r_state;
        w_pc_hold    = 1'b0;
        w_if_id_hold = 1'b0;
        w_if_id_clr  = 1'b0;
        w_id_ex_clr  = 1'b0;
        w_halted     = 1'b0;
        if (!rst) begin
            w_next      = ST_RUN;
            w_if_id_clr = 1'b1;
            w_id_ex_clr = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        w_if_id_clr = 1'b1;
                        w_id_ex_clr = 1'b1;
                    end else if (w_hz || bus.id_halt || bus.id_md_start) begin
                        w_pc_hold    = 1'b1;
                        w_if_id_hold = 1'b1;
                        w_id_ex_clr  = 1'b1;
                        if (w_hz)             w_next = ST_RUN;
                        else if (bus.id_halt) w_next = ST_HALT;
                        else                  w_next = ST_MD_WAIT;
                    end
                end
                ST_MD_WAIT: begin
                    if (bus.ex_branch_taken) begin
                        w_if_id_clr = 1'b1;
                        w_id_ex_clr = 1'b1;
                        w_next      = ST_RUN;
                    end else if (bus.md_done) begin
                        w_next = ST_RUN;
                    end else begin
                        w_pc_hold    = 1'b1;
                        w_if_id_hold = 1'b1;
                        w_id_ex_clr  = 1'b1;
                    end
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                    if (bus.ex_branch_taken) begin
                        w_if_id_clr = 1'b1;
                        w_id_ex_clr = 1'b1;
                        w_next      = ST_RUN;
                    end else begin
                        w_pc_hold    = 1'b1;
                        w_if_id_hold = 1'b1;
                        w_id_ex_clr  = 1'b1;
                        if (bus.go) w_next = ST_RUN;
                    end
                end
                default: begin
                    w_next = ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc_hold    = w_pc_hold;
    assign bus.if_id_hold = w_if_id_hold;
    assign bus.if_id_clr  = w_if_id_clr;
    assign bus.id_ex_clr  = w_id_ex_clr;
    assign bus.halted     = w_halted;
    assign bus.dbg_state  = r_state;

`ifdef PIPE_HAZARD_CTRL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_pc_hold && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.ex_branch_taken && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The counters are 4 bits wide so that saturation is reached.
// Expected counter values are 0 when PIPE_HAZARD_CTRL_CNT_EN is not defined.
module tb_pipe_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_stall;
    int   exp_flush;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output view: {pc_hold, if_id_hold, if_id_clr, id_ex_clr, halted}
    function automatic logic [31:0] outs();
        return {27'd0, bus.pc_hold, bus.if_id_hold, bus.if_id_clr, bus.id_ex_clr, bus.halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall_cnt), 32'(exp_stall));
        chk({tag, "_flush"}, 32'(bus.flush_cnt), 32'(exp_flush));
    endtask

    task automatic set_idle();
        bus.id_rs = '0;  bus.id_rt = '0;  bus.id_rs_use = 1'b0; bus.id_rt_use = 1'b0;
        bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.ex_branch_taken = 1'b0;
        bus.id_halt = 1'b0; bus.go = 1'b0; bus.id_md_start = 1'b0; bus.md_done = 1'b0;
    endtask

    task automatic set_random();
        bus.id_rs = 5'($urandom_range(0, 31)); bus.id_rt = 5'($urandom_range(0, 31));
        bus.ex_rd = 5'($urandom_range(0, 31));
        bus.id_rs_use = 1'($urandom_range(0, 1)); bus.id_rt_use = 1'($urandom_range(0, 1));
        bus.ex_memread = 1'($urandom_range(0, 1)); bus.ex_branch_taken = 1'($urandom_range(0, 1));
        bus.id_halt = 1'($urandom_range(0, 1)); bus.go = 1'($urandom_range(0, 1));
        bus.id_md_start = 1'($urandom_range(0, 1)); bus.md_done = 1'($urandom_range(0, 1));
    endtask

    // One clock: update the expected counters from the expected outputs of this cycle.
    task automatic cycle(input logic exp_hold, input logic exp_br);
        @(posedge clk);
`ifdef PIPE_HAZARD_CTRL_CNT_EN
        if (exp_hold && exp_stall < CNT_MAX) exp_stall++;
        if (exp_br && exp_flush < CNT_MAX)   exp_flush++;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_random();
        #1;
        chk("rst_outs", outs(), 32'b00110);
        exp_stall = 0;
        exp_flush = 0;
        chk_cnt("rst_cnt");
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        #1;
        chk("rst_release", outs(), 32'b00000);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst = 1'b1;
        set_idle();
        #2;
        do_reset();

        // Load-use on rs
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8; bus.id_rs_use = 1'b1;
        #1; chk("lu_rs", outs(), 32'b11010);
        cycle(1'b1, 1'b0);
        set_idle(); #1;
        chk("lu_after", outs(), 32'b00000);
        chk_cnt("lu");

        // Load-use on rt
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd12; bus.id_rt = 5'd12; bus.id_rt_use = 1'b1;
        #1; chk("lu_rt", outs(), 32'b11010);
        cycle(1'b1, 1'b0);

        // Destination r0 never stalls
        set_idle();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rs_use = 1'b1;
        #1; chk("lu_r0", outs(), 32'b00000);
        cycle(1'b0, 1'b0);

        // Matching index with the use bit clear, and a match without a load
        set_idle();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd3; bus.id_rs = 5'd3;
        #1; chk("lu_nouse", outs(), 32'b00000);
        bus.ex_memread = 1'b0; bus.id_rs_use = 1'b1;
        #1; chk("lu_noload", outs(), 32'b00000);
        cycle(1'b0, 1'b0);

        // A taken branch wins over a load-use match
        set_idle();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd9; bus.id_rs = 5'd9; bus.id_rs_use = 1'b1;
        bus.ex_branch_taken = 1'b1;
        #1; chk("br_vs_hz", outs(), 32'b00110);
        cycle(1'b0, 1'b1);
        set_idle(); #1;
        chk_cnt("br");

        // go in RUN is ignored
        bus.go = 1'b1;
        #1; chk("go_run", outs(), 32'b00000);
        cycle(1'b0, 1'b0);
        set_idle(); #1;
        chk("go_run_after", outs(), 32'b00000);

        // Mult/div: md_done in the entry cycle is ignored, then 4 waiting cycles and a done cycle
        do_reset();
        bus.id_md_start = 1'b1; bus.md_done = 1'b1;
        #1; chk("md_entry", outs(), 32'b11010);
        cycle(1'b1, 1'b0);
        set_idle();
        for (int i = 0; i < 4; i++) begin
            #1; chk("md_wait", outs(), 32'b11010);
            cycle(1'b1, 1'b0);
        end
        bus.md_done = 1'b1;
        #1; chk("md_done", outs(), 32'b00000);
        cycle(1'b0, 1'b0);
        set_idle(); #1;
        chk("md_run", outs(), 32'b00000);
        chk_cnt("md");

        // A branch abandons the mult/div wait
        bus.id_md_start = 1'b1;
        #1; chk("md2_entry", outs(), 32'b11010);
        cycle(1'b1, 1'b0);
        set_idle(); bus.ex_branch_taken = 1'b1;
        #1; chk("md2_branch", outs(), 32'b00110);
        cycle(1'b0, 1'b1);
        set_idle(); #1;
        chk("md2_run", outs(), 32'b00000);
        chk_cnt("md2");

        // Halt, wait 10 cycles, then resume with go
        do_reset();
        bus.id_halt = 1'b1;
        #1; chk("halt_entry", outs(), 32'b11010);
        cycle(1'b1, 1'b0);
        set_idle();
        for (int i = 0; i < 10; i++) begin
            #1; chk("halt_wait", outs(), 32'b11011);
            cycle(1'b1, 1'b0);
        end
        bus.go = 1'b1;
        #1; chk("halt_go", outs(), 32'b11011);
        cycle(1'b1, 1'b0);
        set_idle(); #1;
        chk("halt_resumed", outs(), 32'b00000);
        chk_cnt("halt");

        // A load-use hazard takes priority over a halt
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd4; bus.id_rt = 5'd4; bus.id_rt_use = 1'b1;
        bus.id_halt = 1'b1;
        #1; chk("hz_vs_halt", outs(), 32'b11010);
        cycle(1'b1, 1'b0);
        set_idle(); #1;
        chk("hz_vs_halt_after", outs(), 32'b00000);

        // Stall counter saturates during a long halt
        bus.id_halt = 1'b1;
        #1; chk("sat_entry", outs(), 32'b11010);
        cycle(1'b1, 1'b0);
        set_idle();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        #1; chk("sat_halted", outs(), 32'b11011);
        chk_cnt("sat");

        // A branch in HALT flushes and returns to RUN
        bus.ex_branch_taken = 1'b1;
        #1; chk("halt_branch", outs(), 32'b00111);
        cycle(1'b0, 1'b1);
        set_idle(); #1;
        chk("halt_branch_after", outs(), 32'b00000);
        chk_cnt("halt_br");

        // Asynchronous reset in the middle of a halt
        bus.id_halt = 1'b1;
        cycle(1'b1, 1'b0);
        set_idle();
        cycle(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1; chk("async_rst", outs(), 32'b00110);
        chk_cnt("async_rst");
        @(negedge clk);
        rst = 1'b1;
        #1; chk("async_rst_release", outs(), 32'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
